// File: rtl/scs8hd_clkgate_pkg.sv
// Shared types for the gated-clock branch sequencer: FSM state encoding and debug width.
package scs8hd_clkgate_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/scs8hd_clkgate_cnt.sv
// Down-counter shared by the wake-settle and hold-off windows; saturates at zero.
module scs8hd_clkgate_cnt #(
    parameter int CW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [CW-1:0] loadVal_i,
    input  logic          dec_i,
    output logic          zero_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Load wins over decrement; decrement stops at zero so the count never wraps.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadVal_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/scs8hd_clkgate_ctrl.sv
// Sequencer for one gated clock branch: shares the gate between requesters, waits for the
// gated clock to settle before granting, and holds it on through a hysteresis window.
module scs8hd_clkgate_ctrl
    import scs8hd_clkgate_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WAKE_CYC = 2,
    parameter int HOLD_CYC = 8,
    parameter int CW       = 4
) (
    input  logic               CLK,
    input  logic               RESETB,
    input  logic [NREQ-1:0]    REQ,
    input  logic               SCE,
    output logic               GCE,
    output logic [NREQ-1:0]    ACK,
    output logic               BUSY,
    output logic [STATE_W-1:0] STATE
);

    state_e          state_q, state_d;
    logic            gce_q, gce_d;
    logic [NREQ-1:0] ack_q, ack_d;

    logic            anyReq;
    logic            cntLoad;
    logic [CW-1:0]   cntLoadVal;
    logic            cntDec;
    logic            cntZero;

    assign anyReq = |REQ;

    scs8hd_clkgate_cnt #(
        .CW(CW)
    ) u_cnt (
        .clk_i    (CLK),
        .rst_ni   (RESETB),
        .load_i   (cntLoad),
        .loadVal_i(cntLoadVal),
        .dec_i    (cntDec),
        .zero_o   (cntZero)
    );

    // A request seen while HOLD is still counting (even on its last count) returns to ON,
    // so the gate never drops under an active requester.
    always_comb begin
        state_d    = state_q;
        gce_d      = 1'b0;
        ack_d      = '0;
        cntLoad    = 1'b0;
        cntLoadVal = '0;
        cntDec     = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (anyReq) begin
                    state_d    = ST_WAKE;
                    gce_d      = 1'b1;
                    cntLoad    = 1'b1;
                    cntLoadVal = CW'(WAKE_CYC - 1);
                end
            end
            ST_WAKE: begin
                gce_d = 1'b1;
                if (cntZero) begin
                    state_d = ST_ON;
                end else begin
                    cntDec = 1'b1;
                end
            end
            ST_ON: begin
                gce_d = 1'b1;
                ack_d = REQ;
                if (!anyReq) begin
                    state_d    = ST_HOLD;
                    cntLoad    = 1'b1;
                    cntLoadVal = CW'(HOLD_CYC - 1);
                end
            end
            ST_HOLD: begin
                gce_d = 1'b1;
                if (anyReq) begin
                    state_d = ST_ON;
                end else if (cntZero) begin
                    state_d = ST_OFF;
                    gce_d   = 1'b0;
                end else begin
                    cntDec = 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q <= ST_OFF;
            gce_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            gce_q   <= gce_d;
            ack_q   <= ack_d;
        end
    end

    // Scan override is the only combinational path to the gate enable.
    assign GCE   = gce_q | SCE;
    assign ACK   = ack_q;
    assign BUSY  = (state_q != ST_OFF);
    assign STATE = state_q;

endmodule

// File: tb/tb_scs8hd_clkgate_ctrl.sv
// Self-checking bench for scs8hd_clkgate_ctrl: vector table through a scoreboard queue,
// plus hand sequences for reset and the scan override.
module tb_scs8hd_clkgate_ctrl;

    logic       CLK;
    logic       RESETB;
    logic [3:0] REQ;
    logic       SCE;
    logic       GCE;
    logic [3:0] ACK;
    logic       BUSY;
    logic [1:0] STATE;

    typedef struct {
        logic [3:0] req;
        logic       sce;
        logic [1:0] st;
        logic       gce;
        logic [3:0] ack;
    } vec_t;

    vec_t vecs[$];
    vec_t expQ[$];
    int   nTests = 0;
    int   nFail  = 0;

    scs8hd_clkgate_ctrl #(
        .NREQ(4), .WAKE_CYC(2), .HOLD_CYC(8), .CW(4)
    ) dut (
        .CLK   (CLK),
        .RESETB(RESETB),
        .REQ   (REQ),
        .SCE   (SCE),
        .GCE   (GCE),
        .ACK   (ACK),
        .BUSY  (BUSY),
        .STATE (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic addVec(input logic [3:0] r, input logic s, input logic [1:0] st,
                          input logic g, input logic [3:0] a);
        vec_t v;
        v.req = r; v.sce = s; v.st = st; v.gce = g; v.ack = a;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge CLK);
        REQ = v.req;
        SCE = v.sce;
        expQ.push_back(v);
    endtask

    task automatic checkField(input string name, input int actual, input int required);
        nTests++;
        if (actual != required) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    task automatic checkOutput(input string name);
        vec_t e;
        if (expQ.size() == 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL %s: scoreboard empty, got 0 entries, expected 1", name);
        end else begin
            e = expQ.pop_front();
            checkField({name, ".STATE"}, int'(STATE), int'(e.st));
            checkField({name, ".GCE"},   int'(GCE),   int'(e.gce));
            checkField({name, ".ACK"},   int'(ACK),   int'(e.ack));
            checkField({name, ".BUSY"},  int'(BUSY),  int'(e.st != 2'd0));
        end
    endtask

    task automatic expectNow(input string name, input logic [1:0] st, input logic g,
                             input logic [3:0] a);
        vec_t v;
        v.req = REQ; v.sce = SCE; v.st = st; v.gce = g; v.ack = a;
        expQ.push_back(v);
        checkOutput(name);
    endtask

    initial begin
        // Expected state after each edge; WAKE_CYC=2, HOLD_CYC=8.
        addVec(4'b0000, 0, 2'd0, 0, 4'b0000);
        addVec(4'b0001, 0, 2'd1, 1, 4'b0000);
        addVec(4'b0001, 0, 2'd1, 1, 4'b0000);
        addVec(4'b0001, 0, 2'd2, 1, 4'b0000);
        addVec(4'b0001, 0, 2'd2, 1, 4'b0001);
        addVec(4'b1001, 0, 2'd2, 1, 4'b1001);
        addVec(4'b1000, 0, 2'd2, 1, 4'b1000);
        addVec(4'b0000, 0, 2'd3, 1, 4'b0000);
        for (int i = 0; i < 7; i++) addVec(4'b0000, 0, 2'd3, 1, 4'b0000);
        addVec(4'b0000, 0, 2'd0, 0, 4'b0000);
        addVec(4'b0100, 0, 2'd1, 1, 4'b0000);
        addVec(4'b0100, 0, 2'd1, 1, 4'b0000);
        addVec(4'b0100, 0, 2'd2, 1, 4'b0000);
        addVec(4'b0100, 0, 2'd2, 1, 4'b0100);
        for (int i = 0; i < 5; i++) addVec(4'b0000, 0, 2'd3, 1, 4'b0000);
        addVec(4'b0100, 0, 2'd2, 1, 4'b0000);
        addVec(4'b0100, 0, 2'd2, 1, 4'b0100);
        for (int i = 0; i < 8; i++) addVec(4'b0000, 0, 2'd3, 1, 4'b0000);
        addVec(4'b0010, 0, 2'd2, 1, 4'b0000);
        addVec(4'b0010, 0, 2'd2, 1, 4'b0010);
        for (int i = 0; i < 8; i++) addVec(4'b0000, 0, 2'd3, 1, 4'b0000);
        addVec(4'b0000, 0, 2'd0, 0, 4'b0000);
        addVec(4'b0001, 0, 2'd1, 1, 4'b0000);
        addVec(4'b0000, 0, 2'd1, 1, 4'b0000);
        addVec(4'b0000, 0, 2'd2, 1, 4'b0000);
        addVec(4'b0000, 0, 2'd3, 1, 4'b0000);
        for (int i = 0; i < 7; i++) addVec(4'b0000, 0, 2'd3, 1, 4'b0000);
        addVec(4'b0000, 0, 2'd0, 0, 4'b0000);
        addVec(4'b0000, 1, 2'd0, 1, 4'b0000);
        addVec(4'b0000, 0, 2'd0, 0, 4'b0000);
        addVec(4'b0001, 0, 2'd1, 1, 4'b0000);
        addVec(4'b0001, 0, 2'd1, 1, 4'b0000);
        addVec(4'b0001, 0, 2'd2, 1, 4'b0000);
        addVec(4'b0001, 0, 2'd2, 1, 4'b0001);

        RESETB = 1'b0;
        REQ    = 4'b1111;
        SCE    = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        expectNow("resetHold", 2'd0, 0, 4'b0000);

        @(negedge CLK);
        RESETB = 1'b1;
        @(posedge CLK);
        #1;
        expectNow("resetRelease", 2'd1, 1, 4'b0000);

        @(negedge CLK);
        RESETB = 1'b0;
        REQ    = 4'b0000;
        #1;
        expectNow("resetAsyncWake", 2'd0, 0, 4'b0000);
        @(negedge CLK);
        RESETB = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge CLK);
            #1;
            checkOutput($sformatf("vec%0d", i));
        end

        // FSM is ON with ACK=0001; drop reset between edges.
        #2;
        RESETB = 1'b0;
        #1;
        expectNow("midReset", 2'd0, 0, 4'b0000);
        SCE = 1'b1;
        #1;
        expectNow("midResetSce", 2'd0, 1, 4'b0000);
        @(negedge CLK);
        SCE    = 1'b0;
        REQ    = 4'b0000;
        RESETB = 1'b1;
        @(posedge CLK);
        #1;
        expectNow("afterReset", 2'd0, 0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
